// File: rtl/stack_access_ctrl.sv
// stack_access_ctrl: push/pop sequencer between the pipeline, 16-bit data memory and the SP register
//   req_*  : request channel (op 00 PUSH16, 01 POP16, 10 PUSH32, 11 POP32), sp_in sampled at accept
//   mem_*  : word-wide data-memory port, synchronous read (mem_rdata valid the cycle after mem_re)
//   rsp_*  : completion channel, held stable until rsp_ready
//   sp_out/sp_load : new pointer and one-cycle load strobe for the SP register
module stack_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16,
    parameter logic [ADDR_W-1:0] STACK_TOP = 2047,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [31:0]       req_data,
    input  logic [ADDR_W-1:0] sp_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sp_out,
    output logic              sp_load
);
    typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_A, RD_B, RD_W, DONE} state_t;
    state_t            state;
    logic [1:0]        op;
    logic [31:0]       data;
    logic [ADDR_W-1:0] wsp;
    logic              ok;
    // one extra bit so the bounds compares cannot wrap
    logic [ADDR_W:0]   sp_ext, top_ext, lim_ext;
    assign sp_ext  = {1'b0, sp_in};
    assign top_ext = {1'b0, STACK_TOP};
    assign lim_ext = {1'b0, STACK_LIMIT};
    // push16 needs sp >= limit, push32 needs sp >= limit+1 (written as > to stay meaningful at limit 0)
    assign ok = (sp_ext <= top_ext) &&
                (req_op == 2'b00 ? sp_ext + 1 > lim_ext :
                 req_op == 2'b10 ? sp_ext > lim_ext :
                 req_op == 2'b01 ? sp_ext + 1 <= top_ext : sp_ext + 2 <= top_ext);
    assign req_ready = reset && state == IDLE;
    assign sp_load   = rsp_valid && rsp_ready && !rsp_err;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= 2'b00;
            data      <= '0;
            wsp       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            sp_out    <= '0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op       <= req_op;
                        data     <= req_data;
                        wsp      <= sp_in;
                        rsp_data <= '0;
                        if (!ok) begin
                            state     <= DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            sp_out    <= sp_in;
                        end else if (!req_op[0]) begin
                            state     <= WR_A;
                            mem_we    <= 1'b1;
                            mem_addr  <= sp_in;
                            mem_wdata <= req_op[1] ? req_data[31:16] : req_data[15:0];
                        end else begin
                            state    <= RD_A;
                            mem_re   <= 1'b1;
                            mem_addr <= sp_in + 1;
                        end
                    end
                end
                WR_A: begin
                    if (op[1]) begin
                        state     <= WR_B;
                        mem_we    <= 1'b1;
                        mem_addr  <= wsp - 1;
                        mem_wdata <= data[15:0];
                    end else begin
                        state     <= DONE;
                        rsp_valid <= 1'b1;
                        sp_out    <= wsp - 1;
                    end
                end
                WR_B: begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    sp_out    <= wsp - 2;
                end
                RD_A: begin
                    state <= op[1] ? RD_B : RD_W;
                    if (op[1]) begin
                        mem_re   <= 1'b1;
                        mem_addr <= wsp + 2;
                    end
                end
                RD_B: begin
                    state          <= RD_W;
                    rsp_data[15:0] <= mem_rdata;
                end
                RD_W: begin
                    state     <= DONE;
                    rsp_valid <= 1'b1;
                    sp_out    <= op[1] ? wsp + 2 : wsp + 1;
                    if (op[1]) rsp_data[31:16] <= mem_rdata;
                    else rsp_data[15:0] <= mem_rdata;
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stack_access_ctrl.sv
// tb_stack_access_ctrl: directed vector bench for stack_access_ctrl with a synchronous-read memory model
module tb_stack_access_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_data = '0;
    logic [31:0] sp_in = '0;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] sp_out;
    logic        sp_load;
    logic [15:0] mem [0:2047];
    int total = 0;
    int bad = 0;

    stack_access_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .sp_in(sp_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .sp_out(sp_out), .sp_load(sp_load)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[10:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr[10:0]];
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] sp;
        int          hold;
        logic        err;
        logic [31:0] sp_o;
        logic [31:0] rd;
        int          lat;
        int          nwe;
        int          nre;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [15:0] d0;
    } vec_t;

    localparam logic [1:0] PUSH16 = 2'b00, POP16 = 2'b01, PUSH32 = 2'b10, POP32 = 2'b11;
    localparam int NV = 15;
    vec_t v [NV];

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic run(input int i);
        vec_t t;
        int lat, nwe, nre, both;
        logic [31:0] a0, a1;
        logic [15:0] d0;
        bit first, dset;
        t = v[i];
        lat = 1; nwe = 0; nre = 0; both = 0;
        a0 = '0; a1 = '0; d0 = '0; first = 1'b1; dset = 1'b0;
        rsp_ready = (t.hold == 0);
        req_valid = 1'b1;
        req_op = t.op;
        req_data = t.data;
        sp_in = t.sp;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data = ~t.data;
        sp_in = t.sp ^ 32'h55;
        while (lat <= 10) begin
            @(negedge clk);
            if (mem_we || mem_re) begin
                if (first) a0 = mem_addr;
                a1 = mem_addr;
                first = 1'b0;
            end
            if (mem_we && !dset) begin
                d0 = mem_wdata;
                dset = 1'b1;
            end
            if (mem_we) nwe++;
            if (mem_re) nre++;
            if (mem_we && mem_re) both++;
            if (rsp_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("v%0d_lat", i), lat, t.lat);
        for (int h = 0; h < t.hold; h++) begin
            chk($sformatf("v%0d_hold%0d", i, h), {rsp_valid, req_ready, sp_load, rsp_err, sp_out, rsp_data},
                {1'b1, 1'b0, 1'b0, t.err, t.sp_o, t.rd});
            @(posedge clk); #1;
            if (h == t.hold - 1) rsp_ready = 1'b1;
            @(negedge clk);
        end
        chk($sformatf("v%0d_err", i), rsp_err, t.err);
        chk($sformatf("v%0d_sp_out", i), sp_out, t.sp_o);
        chk($sformatf("v%0d_rsp_data", i), rsp_data, t.rd);
        chk($sformatf("v%0d_sp_load", i), {rsp_valid, sp_load, req_ready}, {1'b1, ~t.err, 1'b0});
        chk($sformatf("v%0d_strobes", i), {nwe, nre, both}, {t.nwe, t.nre, 32'd0});
        chk($sformatf("v%0d_addr", i), {a0, a1, d0}, {t.a0, t.a1, t.d0});
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("v%0d_post", i), {sp_load, rsp_valid, req_ready}, 3'b001);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        //      op      data          sp            hold err sp_o          rd            lat we re a0    a1    d0
        v[0]  = '{PUSH16, 32'h000000AB, 32'd2047,     0, 0, 32'd2046,     32'h0,        2, 1, 0, 2047, 2047, 16'h00AB};
        v[1]  = '{PUSH32, 32'h12345678, 32'd2046,     0, 0, 32'd2044,     32'h0,        3, 2, 0, 2046, 2045, 16'h1234};
        v[2]  = '{POP32,  32'h0,        32'd2044,     0, 0, 32'd2046,     32'h12345678, 4, 0, 2, 2045, 2046, 16'h0};
        v[3]  = '{POP16,  32'h0,        32'd2046,     0, 0, 32'd2047,     32'h000000AB, 3, 0, 1, 2047, 2047, 16'h0};
        v[4]  = '{POP16,  32'h0,        32'd2047,     0, 1, 32'd2047,     32'h0,        1, 0, 0, 0,    0,    16'h0};
        v[5]  = '{POP32,  32'h0,        32'd2046,     0, 1, 32'd2046,     32'h0,        1, 0, 0, 0,    0,    16'h0};
        v[6]  = '{PUSH32, 32'hDEADBEEF, 32'd0,        0, 1, 32'd0,        32'h0,        1, 0, 0, 0,    0,    16'h0};
        v[7]  = '{PUSH16, 32'h0000BEEF, 32'd0,        3, 0, 32'hFFFFFFFF, 32'h0,        2, 1, 0, 0,    0,    16'hBEEF};
        v[8]  = '{PUSH16, 32'h00001111, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 32'h0,        1, 0, 0, 0,    0,    16'h0};
        v[9]  = '{POP16,  32'h0,        32'd2045,     0, 0, 32'd2046,     32'h00001234, 3, 0, 1, 2046, 2046, 16'h0};
        v[10] = '{POP32,  32'h0,        32'd2045,     0, 0, 32'd2047,     32'h00AB1234, 4, 0, 2, 2046, 2047, 16'h0};
        v[11] = '{PUSH32, 32'hCAFEF00D, 32'd1,        2, 0, 32'hFFFFFFFF, 32'h0,        3, 2, 0, 1,    0,    16'hCAFE};
        v[12] = '{POP32,  32'h0,        32'hFFFFFFFF, 0, 1, 32'hFFFFFFFF, 32'h0,        1, 0, 0, 0,    0,    16'h0};
        v[13] = '{POP16,  32'h0,        32'd0,        1, 0, 32'd1,        32'h0000CAFE, 3, 0, 1, 1,    1,    16'h0};
        v[14] = '{PUSH16, 32'h00002222, 32'd2048,     0, 1, 32'd2048,     32'h0,        1, 0, 0, 0,    0,    16'h0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b0);
        chk("rst_strobes", {mem_we, mem_re, rsp_valid, rsp_err, sp_load}, 5'b0);
        chk("rst_bus", {mem_addr, mem_wdata, rsp_data, sp_out}, 112'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_ready", req_ready, 1'b1);
        for (int i = 0; i < NV; i++) run(i);
        // reset while PUSH32 is in WR_A: second word must never be written
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op = PUSH32;
        req_data = 32'hCAFEF00D;
        sp_in = 32'd500;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_wr_a", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'd500, 16'hCAFE});
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            cnt += int'(mem_we) + int'(mem_re) + int'(rsp_valid) + int'(sp_load);
        end
        chk("mid_reset_quiet", cnt, 0);
        chk("mid_reset_ready", req_ready, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
